cfg_frame_sequencer: RTL and testbench
======================================

// Module: cfg_frame_sequencer
// PURPOSE
//  Streams a configuration frame into the fabric's per-column shift chains. Sits between the
//  wishbone config front end (word source) and the clb_tile columns (cen / shift_in_hard / set_in_hard).
//  Each 32-bit word is serialized NUM_COLS bits per shift cycle. After CHAIN_BITS shifts, set is pulsed on masked columns.
// PARAMETERS
//  NUM_COLS    4   columns driven in parallel; WORD_W % NUM_COLS == 0
//  WORD_W      32  input word width
//  CHAIN_BITS  16  shift cycles per frame; must be a multiple of WORD_W/NUM_COLS
//  CNT_W       16  width of shift counter; 2**CNT_W > CHAIN_BITS
// PORTS
//  wb_clk_i    in   1         single clock
//  wb_rst_i    in   1         synchronous, active-high reset
//  start       in   1         pulse: begin a frame (ignored unless IDLE)
//  abort       in   1         pulse: drop the frame, return to IDLE, no set pulse
//  col_mask    in   NUM_COLS  columns to program; sampled on the accepted start
//  word_valid  in   1         config word available
//  word_ready  out  1         sequencer accepts word this cycle (valid&&ready = transfer)
//  word_data   in   WORD_W    config word
//  cen         out  1         shift enable, shared by all columns
//  shift_out   out  NUM_COLS  serial data per column (0 for unmasked columns)
//  set_out     out  NUM_COLS  one-cycle latch pulse, masked columns only
//  busy        out  1         high in any state except IDLE
//  done        out  1         one-cycle pulse on frame completion
//  shifts_left out  CNT_W     remaining shift cycles in the current frame
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including word_ready and shifts_left. Shift register and mask cleared.
//  FSM: IDLE -start-> LOAD; LOAD -xfer-> SHIFT.
//   SHIFT -word empty && shifts_left>0-> LOAD; SHIFT -last shift-> SET; SET -> DONE; DONE -> IDLE.
//  IDLE: on start, latch col_mask and load shifts_left=CHAIN_BITS.
//  LOAD: word_ready=1, cen=0. On transfer, capture word_data into sreg and set sub-count=WORD_W/NUM_COLS.
//  SHIFT: cen=1 and shift_out=sreg[NUM_COLS-1:0]&mask. Then sreg>>=NUM_COLS; shifts_left and sub-count decrement.
//   Shift k of a word carries word[k*NUM_COLS +: NUM_COLS]; bit c drives column c (LSB first).
//  SET: cen=0 and set_out=mask for exactly one cycle. DONE: done=1 for one cycle.
//  Latency: a word transferred in cycle t produces its first shift in cycle t+1.
//  Boundaries:
//   - word_valid low in LOAD: stall; cen stays 0 and chain contents are preserved.
//   - start while busy: ignored.
//   - abort: wins over every other event, including in SET. Next cycle IDLE, set_out=0, done=0.
//     A word offered in the abort cycle is not accepted (word_ready forced 0).
//   - col_mask==0: the frame still consumes all words and shifts; set_out stays 0; done still pulses.
//   - wb_rst_i mid-frame: identical to the reset state; no set pulse.
//   - Words beyond the frame are not consumed (word_ready=0 outside LOAD).
// CONFIGURATION
//  CFG_PREFETCH_EN defined:
//   - A one-word holding buffer is added; word_ready=1 in SHIFT while the buffer is empty.
//   - When sreg empties and the buffer is full, SHIFT continues with no LOAD bubble (gapless cen).
//   - The buffer is cleared by reset, abort and frame end; a word is never accepted past the frame's word count.
//  CFG_PREFETCH_EN undefined:
//   - One LOAD cycle (cen=0) separates the shift bursts of consecutive words.
//   - With word_valid held high, a frame takes WORDS*(1+WORD_W/NUM_COLS)+2 cycles after the start cycle.
// STRUCTURE
//  Package cfg_seq_pkg:
//   - state encoding: IDLE, LOAD, SHIFT, SET, DONE
//   - SHIFTS_PER_WORD = WORD_W/NUM_COLS
//   - WORDS_PER_FRAME = CHAIN_BITS/SHIFTS_PER_WORD
//  Sub-module cfg_word_serializer:
//   - holds sreg and sub-count (plus the prefetch buffer when enabled)
//   - ports: load, advance, empty, bits out
//  The top level holds the FSM, the mask and the frame counter.
// TESTING (NUM_COLS=4, WORD_W=32, CHAIN_BITS=16)
//  1. Reset, start, col_mask=4'hF, words 0x76543210 then 0xFEDCBA98 always valid:
//     - shift_out = 0..7 on eight cen cycles, then 8..F
//     - set_out = 4'hF once, then done once; shifts_left counts 16 down to 0
//  2. col_mask=4'b0101, word 0xFFFFFFFF twice: shift_out=4'b0101 on every cen cycle; set_out=4'b0101.
//  3. word_valid low for 5 cycles in LOAD: cen=0 for those cycles; the output sequence is unchanged vs test 1.
//  4. abort on the 3rd SHIFT cycle: busy falls next cycle; set_out and done never assert.
//     A new start then reruns test 1 exactly.
//  5. start pulsed again mid-frame and a third word offered after the frame: both ignored; word_ready=0 in IDLE.
//  6. CFG_PREFETCH_EN with words always valid: 16 consecutive cen cycles with no gap; done 2 cycles after the last shift.

Source files
------------

// File: rtl/cfg_frame_sequencer_pkg.sv
// Shared constants and state encoding for the configuration frame sequencer.
package cfg_seq_pkg;

  localparam int NUM_COLS        = 4;
  localparam int WORD_W          = 32;
  localparam int CHAIN_BITS      = 16;
  localparam int CNT_W           = 16;
  localparam int SHIFTS_PER_WORD = WORD_W / NUM_COLS;
  localparam int WORDS_PER_FRAME = CHAIN_BITS / SHIFTS_PER_WORD;
  localparam int SUB_W           = $clog2(SHIFTS_PER_WORD + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SET,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/cfg_frame_sequencer_if.sv
// Config word handshake between the wishbone front end (master) and the sequencer (slave).
interface cfg_frame_sequencer_if;
  import cfg_seq_pkg::*;

  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/cfg_frame_sequencer_serializer.sv
// Word serializer: shifts a config word out NUM_COLS bits at a time, LSB first.
// With CFG_PREFETCH_EN a one-word holding buffer lets the next word follow without a gap.
module cfg_word_serializer
  import cfg_seq_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                clear,
  input  logic                load,
  input  logic                advance,
`ifdef CFG_PREFETCH_EN
  input  logic                push,
  output logic                buf_empty,
`endif
  input  logic [WORD_W-1:0]   data,
  output logic                empty,
  output logic [NUM_COLS-1:0] bits
);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic              last_bits;

  assign last_bits = (sub_cnt_q <= SUB_W'(1));
  assign bits      = sreg_q[NUM_COLS-1:0];

`ifdef CFG_PREFETCH_EN
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;

  assign buf_empty = !buf_full_q;
  // Empty means nothing is left to shift after the current advance.
  assign empty     = last_bits && !buf_full_q && !push;
`else
  assign empty     = last_bits;
`endif

  always_comb begin
    sreg_d    = sreg_q;
    sub_cnt_d = sub_cnt_q;
`ifdef CFG_PREFETCH_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`endif
    if (clear) begin
      sreg_d    = '0;
      sub_cnt_d = '0;
`ifdef CFG_PREFETCH_EN
      buf_d      = '0;
      buf_full_d = 1'b0;
`endif
    end else if (load) begin
      sreg_d    = data;
      sub_cnt_d = SUB_W'(SHIFTS_PER_WORD);
    end else if (advance) begin
      sreg_d    = sreg_q >> NUM_COLS;
      sub_cnt_d = sub_cnt_q - SUB_W'(1);
`ifdef CFG_PREFETCH_EN
      if (sub_cnt_q == SUB_W'(1)) begin
        if (buf_full_q) begin
          sreg_d     = buf_q;
          sub_cnt_d  = SUB_W'(SHIFTS_PER_WORD);
          buf_full_d = 1'b0;
        end else if (push) begin
          sreg_d    = data;
          sub_cnt_d = SUB_W'(SHIFTS_PER_WORD);
        end
      end else if (push) begin
        buf_d      = data;
        buf_full_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sreg_q    <= '0;
      sub_cnt_q <= '0;
`ifdef CFG_PREFETCH_EN
      buf_q      <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      sreg_q    <= sreg_d;
      sub_cnt_q <= sub_cnt_d;
`ifdef CFG_PREFETCH_EN
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

endmodule

// File: rtl/cfg_frame_sequencer.sv
// Config frame sequencer: streams words into the column shift chains, then pulses set.
// Optional CFG_PREFETCH_EN adds a holding buffer for gapless shifting across words.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_LOAD  | word_ready high, waiting for a config word
//   ST_SHIFT | cen high, one NUM_COLS-bit slice per cycle
//   ST_SET   | one-cycle set pulse on masked columns
//   ST_DONE  | one-cycle done pulse
module cfg_frame_sequencer
  import cfg_seq_pkg::*;
(
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_COLS-1:0]  col_mask,
  cfg_frame_sequencer_if.slave word_if,
  output logic                 cen,
  output logic [NUM_COLS-1:0]  shift_out,
  output logic [NUM_COLS-1:0]  set_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     shifts_left
);

  seq_state_e          state_q, state_d;
  logic [NUM_COLS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    shifts_left_q, shifts_left_d;
  logic                xfer, ser_load, ser_advance, ser_clear, ser_empty;
  logic [NUM_COLS-1:0] ser_bits;

`ifdef CFG_PREFETCH_EN
  logic             ser_push, ser_buf_empty;
  logic [CNT_W-1:0] words_left_q, words_left_d;

  // Words never get accepted beyond what the frame still needs.
  assign word_if.word_ready = !abort &&
                              ((state_q == ST_LOAD) ||
                               (state_q == ST_SHIFT && ser_buf_empty && words_left_q != '0));
  assign ser_push = xfer && (state_q == ST_SHIFT);
`else
  assign word_if.word_ready = !abort && (state_q == ST_LOAD);
`endif

  assign xfer        = word_if.word_valid && word_if.word_ready;
  assign ser_load    = xfer && (state_q == ST_LOAD);
  assign ser_advance = (state_q == ST_SHIFT) && !abort;
  assign ser_clear   = abort || (state_q == ST_SET);
  assign busy        = (state_q != ST_IDLE);
  assign shifts_left = shifts_left_q;

  cfg_word_serializer u_ser (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clear     (ser_clear),
    .load      (ser_load),
    .advance   (ser_advance),
`ifdef CFG_PREFETCH_EN
    .push      (ser_push),
    .buf_empty (ser_buf_empty),
`endif
    .data      (word_if.word_data),
    .empty     (ser_empty),
    .bits      (ser_bits)
  );

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    shifts_left_d = shifts_left_q;
    cen           = 1'b0;
    shift_out     = '0;
    set_out       = '0;
    done          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD;
          mask_d        = col_mask;
          shifts_left_d = CNT_W'(CHAIN_BITS);
        end
      end
      ST_LOAD: begin
        if (xfer) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        cen           = 1'b1;
        shift_out     = ser_bits & mask_q;
        shifts_left_d = shifts_left_q - CNT_W'(1);
        if (shifts_left_q == CNT_W'(1)) state_d = ST_SET;
        else if (ser_empty)             state_d = ST_LOAD;
      end
      ST_SET: begin
        set_out = mask_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a pending set pulse.
    if (abort) begin
      state_d       = ST_IDLE;
      shifts_left_d = '0;
      cen           = 1'b0;
      shift_out     = '0;
      set_out       = '0;
      done          = 1'b0;
    end
  end

`ifdef CFG_PREFETCH_EN
  always_comb begin
    words_left_d = words_left_q;
    if (state_q == ST_IDLE && start)  words_left_d = CNT_W'(WORDS_PER_FRAME);
    else if (xfer)                    words_left_d = words_left_q - CNT_W'(1);
    if (abort)                        words_left_d = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) words_left_q <= '0;
    else          words_left_q <= words_left_d;
  end
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      shifts_left_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      shifts_left_q <= shifts_left_d;
    end
  end

endmodule

// File: tb/tb_cfg_frame_sequencer.sv
// Directed bench for cfg_frame_sequencer; frame timing expectations follow CFG_PREFETCH_EN.
module tb_cfg_frame_sequencer;
  import cfg_seq_pkg::*;

`ifdef CFG_PREFETCH_EN
  localparam int DONE_CYC  = 19;
  localparam int MAX_RUN   = 16;
  localparam int XFER_ABRT = 2;
`else
  localparam int DONE_CYC  = 20;
  localparam int MAX_RUN   = 8;
  localparam int XFER_ABRT = 1;
`endif
  localparam int SET_CYC = DONE_CYC - 1;

  logic                clk;
  logic                rst;
  logic                start;
  logic                abort;
  logic [NUM_COLS-1:0] col_mask;
  logic                cen;
  logic [NUM_COLS-1:0] shift_out;
  logic [NUM_COLS-1:0] set_out;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    shifts_left;

  cfg_frame_sequencer_if wif ();

  cfg_frame_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start       (start),
    .abort       (abort),
    .col_mask    (col_mask),
    .word_if     (wif.slave),
    .cen         (cen),
    .shift_out   (shift_out),
    .set_out     (set_out),
    .busy        (busy),
    .done        (done),
    .shifts_left (shifts_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sh_log[$];
  int set_cnt, done_cnt, cyc_set, cyc_done, cyc_last, cyc_idle, max_run, n_xfer;
  logic [3:0] set_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cen"}, 32'(cen), 0);
    chk({tag, "_shift_out"}, 32'(shift_out), 0);
    chk({tag, "_set_out"}, 32'(set_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_shifts_left"}, 32'(shifts_left), 0);
    chk({tag, "_word_ready"}, 32'(wif.word_ready), 0);
  endtask

  // One frame: start in cycle 0, optional valid stall, abort and ignored restart.
  task automatic run_frame(input logic [3:0] mask, input logic [31:0] w0, input logic [31:0] w1,
                           input int stall, input int abort_at, input int restart_at);
    logic [31:0] words [3];
    int widx, run, post;
    words[0] = w0;
    words[1] = w1;
    words[2] = 32'h5A5A_C3C3;
    sh_log.delete();
    set_cnt = 0; set_val = '0; done_cnt = 0; cyc_set = -1; cyc_done = -1;
    cyc_last = -1; cyc_idle = -1; max_run = 0; n_xfer = 0;
    widx = 0; run = 0; post = 0;
    for (int c = 0; c < 100 && post < 4; c++) begin
      start          = (c == 0) || (c == restart_at);
      col_mask       = (c == 0) ? mask : ~mask;
      abort          = (c == abort_at);
      wif.word_valid = (c > stall);
      wif.word_data  = words[widx];
      @(negedge clk);
      if (cen) begin
        chk("shifts_left", 32'(shifts_left), CHAIN_BITS - sh_log.size());
        sh_log.push_back(shift_out);
        run++;
        cyc_last = c;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (c >= 1 && c <= stall) chk("stall_cen", 32'(cen), 0);
      if (set_out != '0) begin set_cnt++; set_val = set_out; cyc_set = c; end
      if (done) begin done_cnt++; cyc_done = c; end
      if (cyc_idle >= 0) begin
        chk("idle_word_ready", 32'(wif.word_ready), 0);
        post++;
      end else if (c > 0 && !busy) begin
        cyc_idle = c;
        chk("idle_shifts_left", 32'(shifts_left), 0);
      end
      if (wif.word_valid && wif.word_ready) begin
        n_xfer++;
        if (widx < 2) widx++;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; wif.word_valid = 1'b0;
    chk("frame_ended", 32'(cyc_idle >= 0), 1);
  endtask

  task automatic chk_counting(input string tag, input int exp_done);
    chk({tag, "_nshift"}, sh_log.size(), 16);
    for (int i = 0; i < sh_log.size() && i < 16; i++) chk({tag, "_shift"}, 32'(sh_log[i]), i);
    chk({tag, "_set_cnt"}, set_cnt, 1);
    chk({tag, "_set_val"}, 32'(set_val), 4'hF);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, cyc_done, exp_done);
    chk({tag, "_set_cyc"}, cyc_set, exp_done - 1);
    chk({tag, "_last_to_done"}, cyc_done - cyc_last, 2);
    chk({tag, "_max_cen_run"}, max_run, MAX_RUN);
    chk({tag, "_n_xfer"}, n_xfer, 2);
  endtask

  initial begin
    int spurious;
    rst = 1'b1; start = 1'b0; abort = 1'b0; col_mask = '0;
    wif.word_valid = 1'b0; wif.word_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: basic counting frame.
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 0, -1, -1);
    chk_counting("t1", DONE_CYC);

    // Test 2: partial mask, mask input changes after start must not matter.
    run_frame(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, -1);
    chk("t2_nshift", sh_log.size(), 16);
    for (int i = 0; i < sh_log.size(); i++) chk("t2_shift", 32'(sh_log[i]), 4'b0101);
    chk("t2_set_cnt", set_cnt, 1);
    chk("t2_set_val", 32'(set_val), 4'b0101);
    chk("t2_done_cnt", done_cnt, 1);

    // Test 3: five-cycle stall in LOAD.
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 5, -1, -1);
    chk_counting("t3", DONE_CYC + 5);

    // Test 4: abort on the third SHIFT cycle, then a clean rerun.
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 0, 4, -1);
    chk("t4_idle_cyc", cyc_idle, 5);
    chk("t4_set_cnt", set_cnt, 0);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_n_xfer", n_xfer, XFER_ABRT);
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 0, -1, -1);
    chk_counting("t4_rerun", DONE_CYC);

    // Test 5: start mid-frame and an extra word after the frame are ignored.
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 0, -1, 6);
    chk_counting("t5", DONE_CYC);

    // Abort during SET suppresses the set and done pulses.
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 0, SET_CYC, -1);
    chk("abort_set_nshift", sh_log.size(), 16);
    chk("abort_set_set_cnt", set_cnt, 0);
    chk("abort_set_done_cnt", done_cnt, 0);
    chk("abort_set_idle_cyc", cyc_idle, SET_CYC + 1);

    // Empty mask: words consumed, no set, done still pulses.
    run_frame(4'h0, 32'h7654_3210, 32'hFEDC_BA98, 0, -1, -1);
    chk("mask0_nshift", sh_log.size(), 16);
    for (int i = 0; i < sh_log.size(); i++) chk("mask0_shift", 32'(sh_log[i]), 0);
    chk("mask0_set_cnt", set_cnt, 0);
    chk("mask0_done_cnt", done_cnt, 1);
    chk("mask0_done_cyc", cyc_done, DONE_CYC);
    chk("mask0_n_xfer", n_xfer, 2);

    // Reset in the middle of a frame.
    start = 1'b1; col_mask = 4'hF;
    wif.word_valid = 1'b1; wif.word_data = 32'h7654_3210;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_pre_cen", 32'(cen), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_quiet("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wif.word_valid = 1'b0;
    spurious = 0;
    repeat (25) begin
      @(negedge clk);
      if (set_out != '0 || done || busy || cen) spurious++;
    end
    chk("midrst_after_quiet", spurious, 0);

    // Same bench after reset gives the counting frame again.
    @(posedge clk);
    #1;
    run_frame(4'hF, 32'h7654_3210, 32'hFEDC_BA98, 0, -1, -1);
    chk_counting("post_rst", DONE_CYC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
